cpu16_core: RTL and testbench
=============================

# cpu16_core

16-bit multicycle processor core: control FSM, 16×16-bit register bank, ALU with multiplier. It sits between an external synchronous instruction ROM (12-bit address, one-cycle read latency) and the top level. It fetches, decodes, executes and writes back one instruction every 4 clocks, and exposes a debug read port for verification.

## Interface
- RESET_PC, 12'h000, PC value loaded on reset.

- CLOCK_50  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- inst  in  16  ROM data for the address presented on `pc` in the previous cycle.
- pc  out  12  instruction address; drives the ROM.
- retire  out  1  high for exactly one cycle, in the WRITEBACK state of each completed instruction.
- halted  out  1  high once HALT has retired; cleared only by reset.
- dbg_sel  in  4  register index for debug read.
- dbg_data  out  16  combinational read of R[dbg_sel]; 0 when dbg_sel = 0.

## Operation
- Instruction fields: op = inst[15:12], rc = [11:8] (destination/test), ra = [7:4], rb = [3:0], imm4 = [3:0], imm8 = [7:0], imm12 = [11:0].
- Register bank: R0 always reads 0, and writes to it are dropped. R1–R15 are 16-bit.
- One write port, used in WRITEBACK. Reads are combinational.
- Internal HI register (16 bit) holds the upper product half.
- Opcodes:
  - 0 ADD: rc = ra + rb
  - 1 SUB: rc = ra − rb
  - 2 AND: rc = ra & rb
  - 3 OR: rc = ra | rb
  - 4 XOR: rc = ra ^ rb
  - 5 SLT: rc = 1 if signed ra < signed rb, else 0
  - 6 SHL: rc = ra << imm4
  - 7 SHR: rc = ra >> imm4, logical
  - 8 ADDI: rc = ra + zext(imm4)
  - 9 MUL: unsigned 32-bit product; rc = low 16 bits, HI = high 16 bits
  - A MFHI: rc = HI
  - B BEQZ: if R[rc] == 0 then pc = {4'h0, imm8}, else pc + 1
  - C JMP: pc = imm12
  - D LI: rc = sext(imm8)
  - E NOP
  - F HALT
- Arithmetic wraps modulo 2^16; there are no flags or traps.
- ALU zero = (result == 0). BEQZ uses this with the ALU passing R[rc].
- Non-control instructions: pc ← pc + 1, wrapping 0xFFF → 0x000.
- HALT: pc unchanged, halted ← 1, and the FSM parks in HALTED with no further fetches.

## Timing
- States: FETCH → DECODE → EXECUTE → WRITEBACK → FETCH. HALT goes WRITEBACK → HALTED.
- FETCH: `pc` is stable, and the ROM registers the word at the end of the cycle.
- DECODE: `inst` is valid and latched into the IR at the end of the cycle.
- EXECUTE: the ALU or multiplier computes from the IR and current register reads; the result, zero flag and HI candidate are registered.
- WRITEBACK:
  - The register write and HI update are committed at the end of the cycle.
  - pc updates at the end of the cycle.
  - retire = 1.
- CPI = 4. The first retire occurs in cycle 4 after reset deasserts; cycles are counted from 1.
- A write in WRITEBACK is visible to the next instruction's EXECUTE. There are no hazards because execution is serial.
- Reset, when sampled high in any state including mid-instruction or HALTED:
  - state = FETCH, pc = RESET_PC, IR = 0, HI = 0, R1–R15 = 0.
  - retire = 0, halted = 0.
  - The in-flight instruction is discarded with no writeback.
- Reset has priority over all other updates in the same edge.

## Test plan
- Reset then LI R1,0x7F; LI R2,0xFE (sext 0xFFFE); ADD R3,R1,R2 → dbg R3 = 0x007D. retire pulses every 4th cycle, and pc = 3 after the third retire.
- LI R1,0xFF; MUL R4,R1,R1 (0xFFFF²); MFHI R5 → R4 = 0x0001, R5 = 0xFFFE. SUB of 0 − 1 gives 0xFFFF.
- LI R0,5 then read dbg_sel = 0 → 0. SLT with 0x8000 vs 0x0001 → 1. SHR 0x8000 by 15 → 0x0001.
- BEQZ R0 to 0x20 → next pc = 0x020. BEQZ with R1 = 3 → pc + 1. JMP 0xFFF, then NOP → pc wraps to 0x000.
- HALT at address 2 → halted = 1, pc stays 2, retire never pulses again. A reset pulse → pc = 0, halted = 0, all registers 0.
- Assert reset during EXECUTE of ADD R3 → R3 stays 0, and execution restarts at pc 0 with fetch on the cycle after release.

Source files
------------

// File: rtl/cpu16_core_if.sv
// cpu16_core_if: instruction ROM bus plus status and debug read port of the core
interface cpu16_core_if;
  logic [11:0] pc;
  logic [15:0] inst;
  logic        retire;
  logic        halted;
  logic [3:0]  dbg_sel;
  logic [15:0] dbg_data;
  modport master (output pc, retire, halted, dbg_data, input inst, dbg_sel);
  modport slave (input pc, retire, halted, dbg_data, output inst, dbg_sel);
endinterface

// File: rtl/cpu16_core.sv
// cpu16_core: 16-bit multicycle core, FETCH/DECODE/EXECUTE/WRITEBACK, one instruction per 4 clocks
module cpu16_core #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input logic CLOCK_50,
  input logic reset,
  cpu16_core_if.master bus
);
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALTED} state_t;
  state_t state, next_state;
  logic [15:0] regs [16];
  logic [15:0] ir, res, hi, hi_c, alu, ra_v, rb_v, rc_v;
  logic [31:0] prod;
  logic [11:0] pc;
  logic zero, halted, wen;
  wire [3:0] op = ir[15:12];
  wire [3:0] rc = ir[11:8];
  assign ra_v = regs[ir[7:4]];
  assign rb_v = regs[ir[3:0]];
  assign rc_v = regs[rc];
  assign prod = {16'd0, ra_v} * {16'd0, rb_v};
  assign wen = op <= 4'hA || op == 4'hD;
  assign bus.pc = pc;
  assign bus.halted = halted;
  assign bus.retire = state == WRITEBACK;
  assign bus.dbg_data = regs[bus.dbg_sel];
  always_comb begin
    next_state = HALTED;
    case (state)
      FETCH:     next_state = DECODE;
      DECODE:    next_state = EXECUTE;
      EXECUTE:   next_state = WRITEBACK;
      WRITEBACK: next_state = op == 4'hF ? HALTED : FETCH;
      default:   next_state = HALTED;
    endcase
  end
  always_comb begin
    alu = '0;
    case (op)
      4'h0: alu = ra_v + rb_v;
      4'h1: alu = ra_v - rb_v;
      4'h2: alu = ra_v & rb_v;
      4'h3: alu = ra_v | rb_v;
      4'h4: alu = ra_v ^ rb_v;
      4'h5: alu = {15'd0, $signed(ra_v) < $signed(rb_v)};
      4'h6: alu = ra_v << ir[3:0];
      4'h7: alu = ra_v >> ir[3:0];
      4'h8: alu = ra_v + {12'd0, ir[3:0]};
      4'h9: alu = prod[15:0];
      4'hA: alu = hi;
      4'hB: alu = rc_v;
      4'hD: alu = {{8{ir[7]}}, ir[7:0]};
      default: alu = '0;
    endcase
  end
  // R0 is reset to zero and never written, so plain array reads give the hard-wired zero
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      hi <= '0;
      hi_c <= '0;
      res <= '0;
      zero <= 1'b0;
      halted <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      state <= next_state;
      if (state == DECODE) ir <= bus.inst;
      if (state == EXECUTE) begin
        res <= alu;
        zero <= alu == '0;
        hi_c <= prod[31:16];
      end
      if (state == WRITEBACK) begin
        if (wen && rc != 4'd0) regs[rc] <= res;
        if (op == 4'h9) hi <= hi_c;
        if (op == 4'hF) halted <= 1'b1;
        pc <= op == 4'hB ? (zero ? {4'h0, ir[7:0]} : pc + 12'd1) :
              op == 4'hC ? ir[11:0] :
              op == 4'hF ? pc : pc + 12'd1;
      end
    end
  end
endmodule

// File: tb/tb_cpu16_core.sv
// tb_cpu16_core: randomized and directed programs checked against an ISA-level model
module tb_cpu16_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cpu16_core_if bus();
  cpu16_core dut (.CLOCK_50(clk), .reset(rst), .bus(bus));
  logic [15:0] rom [4096];
  always @(posedge clk) bus.inst <= rom[bus.pc];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] m_r [16];
  logic [15:0] m_hi;
  logic [11:0] m_pc;
  logic m_halt;
  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_hi = '0;
    m_pc = '0;
    m_halt = 1'b0;
  endtask
  task automatic put(input logic [3:0] i, input logic [15:0] v);
    if (i != 4'd0) m_r[i] = v;
  endtask
  task automatic model_step();
    logic [15:0] w = rom[m_pc];
    logic [3:0] rc = w[11:8];
    logic [15:0] a = m_r[w[7:4]];
    logic [15:0] b = m_r[w[3:0]];
    logic [31:0] p;
    logic [11:0] np = m_pc + 12'd1;
    case (w[15:12])
      4'h0: put(rc, a + b);
      4'h1: put(rc, a - b);
      4'h2: put(rc, a & b);
      4'h3: put(rc, a | b);
      4'h4: put(rc, a ^ b);
      4'h5: put(rc, $signed(a) < $signed(b) ? 16'd1 : 16'd0);
      4'h6: put(rc, a << w[3:0]);
      4'h7: put(rc, a >> w[3:0]);
      4'h8: put(rc, a + {12'd0, w[3:0]});
      4'h9: begin p = {16'd0, a} * {16'd0, b}; put(rc, p[15:0]); m_hi = p[31:16]; end
      4'hA: put(rc, m_hi);
      4'hB: if (m_r[rc] == 16'd0) np = {4'h0, w[7:0]};
      4'hC: np = w[11:0];
      4'hD: put(rc, {{8{w[7]}}, w[7:0]});
      4'hF: begin np = m_pc; m_halt = 1'b1; end
      default: ;
    endcase
    m_pc = np;
  endtask
  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 16'hF000;
  endtask
  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc = 1;
  endtask
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      logic [3:0] rc;
      while (!bus.retire && cyc < 8) begin @(negedge clk); cyc++; end
      checks++;
      if (!bus.retire || cyc != 4) begin
        errors++;
        $display("FAIL retire_timing: retire=%0b after %0d cycles, expected 1 after 4", bus.retire, cyc);
      end
      if (!bus.retire) return;
      rc = rom[m_pc][11:8];
      model_step();
      @(posedge clk); #1;
      bus.dbg_sel = rc; #1;
      checks++;
      if (bus.pc !== m_pc) begin errors++; $display("FAIL step_pc: got %h expected %h", bus.pc, m_pc); end
      checks++;
      if (bus.dbg_data !== m_r[rc]) begin errors++; $display("FAIL step_reg R%0d: got %h expected %h", rc, bus.dbg_data, m_r[rc]); end
      checks++;
      if (bus.halted !== m_halt || bus.retire !== 1'b0) begin
        errors++;
        $display("FAIL step_status: halted=%b retire=%b expected halted=%b retire=0", bus.halted, bus.retire, m_halt);
      end
      cyc = 0;
    end
  endtask
  task automatic reg_sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      bus.dbg_sel = 4'(i); #1;
      checks++;
      if (bus.dbg_data !== m_r[i]) begin errors++; $display("FAIL %s R%0d: got %h expected %h", tag, i, bus.dbg_data, m_r[i]); end
    end
  endtask
  task automatic expect_reg(input string tag, input logic [3:0] r, input logic [15:0] v);
    bus.dbg_sel = r; #1;
    checks++;
    if (bus.dbg_data !== v) begin errors++; $display("FAIL %s: got %h expected %h", tag, bus.dbg_data, v); end
  endtask
  task automatic test_reset();
    clear_rom();
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk); #1;
    checks++;
    if (bus.pc !== 12'h000 || bus.retire !== 1'b0 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h retire=%b halted=%b expected 000/0/0", bus.pc, bus.retire, bus.halted);
    end
    reg_sweep("reset_regs");
  endtask
  task automatic test_basic();
    clear_rom();
    rom[0] = 16'hD17F; rom[1] = 16'hD2FE; rom[2] = 16'h0312;
    do_reset();
    run(3);
    expect_reg("li_sext", 4'd2, 16'hFFFE);
    expect_reg("add_r3", 4'd3, 16'h007D);
    checks++;
    if (bus.pc !== 12'd3) begin errors++; $display("FAIL pc_after_3: got %h expected 003", bus.pc); end
  endtask
  task automatic test_mul();
    clear_rom();
    rom[0] = 16'hD1FF; rom[1] = 16'h9411; rom[2] = 16'hA500; rom[3] = 16'hD701; rom[4] = 16'h1607;
    do_reset();
    run(6);
    expect_reg("mul_lo", 4'd4, 16'h0001);
    expect_reg("mfhi", 4'd5, 16'hFFFE);
    expect_reg("sub_wrap", 4'd6, 16'hFFFF);
  endtask
  task automatic test_misc();
    clear_rom();
    rom[0] = 16'hD005; rom[1] = 16'hD101; rom[2] = 16'h611F; rom[3] = 16'hD201;
    rom[4] = 16'h5312; rom[5] = 16'h741F;
    do_reset();
    run(7);
    expect_reg("r0_zero", 4'd0, 16'h0000);
    expect_reg("shl15", 4'd1, 16'h8000);
    expect_reg("slt_signed", 4'd3, 16'h0001);
    expect_reg("shr_logical", 4'd4, 16'h0001);
  endtask
  task automatic test_branch();
    clear_rom();
    rom[0] = 16'hB020; rom[12'h020] = 16'hD103; rom[12'h021] = 16'hB140;
    rom[12'h022] = 16'hCFFF; rom[12'hFFF] = 16'hE000;
    do_reset();
    run(1);
    checks++;
    if (bus.pc !== 12'h020) begin errors++; $display("FAIL beqz_taken: got %h expected 020", bus.pc); end
    run(2);
    checks++;
    if (bus.pc !== 12'h022) begin errors++; $display("FAIL beqz_not_taken: got %h expected 022", bus.pc); end
    run(2);
    checks++;
    if (bus.pc !== 12'h000) begin errors++; $display("FAIL pc_wrap: got %h expected 000", bus.pc); end
  endtask
  task automatic test_halt();
    logic seen = 1'b0;
    clear_rom();
    rom[0] = 16'hD109; rom[1] = 16'hD204;
    do_reset();
    run(3);
    repeat (20) begin @(negedge clk); if (bus.retire) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0 || bus.pc !== 12'd2 || bus.halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_park: retire_seen=%b pc=%h halted=%b expected 0/002/1", seen, bus.pc, bus.halted);
    end
    reg_sweep("halt_regs");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    checks++;
    if (bus.pc !== 12'h000 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: pc=%h halted=%b expected 000/0", bus.pc, bus.halted);
    end
    reg_sweep("halt_reset_regs");
  endtask
  task automatic test_reset_mid();
    clear_rom();
    rom[0] = 16'hD101; rom[1] = 16'hD202; rom[2] = 16'h0312;
    do_reset();
    run(2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    checks++;
    if (bus.pc !== 12'h000 || bus.retire !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: pc=%h retire=%b expected 000/0", bus.pc, bus.retire);
    end
    expect_reg("mid_reset_r3", 4'd3, 16'h0000);
    expect_reg("mid_reset_r1", 4'd1, 16'h0000);
    @(negedge clk) rst = 1'b0;
    cyc = 1;
    run(4);
    expect_reg("rerun_r3", 4'd3, 16'h0003);
  endtask
  task automatic test_random();
    logic [3:0] ops [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hD, 4'hE};
    repeat (3) begin
      clear_rom();
      for (int i = 0; i < 24; i++) rom[i] = {ops[$urandom_range(0, 12)], 12'($urandom)};
      do_reset();
      run(25);
      reg_sweep("random_regs");
    end
  endtask
  initial begin
    bus.dbg_sel = 4'd0;
    test_reset();
    test_basic();
    test_mul();
    test_misc();
    test_branch();
    test_halt();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
